// File: rtl/cp_s1_stride_ram_reader_if.sv
// Stream and RAM-read bus bundle for the stage-1 stride RAM reader.
// master: the reader (drives RAM address/enable and the output stream).
// slave:  the surrounding RAM and downstream consumer.
interface cp_s1_stride_ram_reader_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned READ_RAM_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]     o_m0_rd_addr;
    logic                      o_m0_rd_en;
    logic [READ_RAM_WIDTH-1:0] i_m0_rd_data;
    logic [READ_RAM_WIDTH-1:0] o_data;
    logic                      o_data_valid;
    logic                      i_data_ready;
    logic                      o_data_last;
    logic                      o_frame_last;

    modport master (
        output o_m0_rd_addr,
        output o_m0_rd_en,
        input  i_m0_rd_data,
        output o_data,
        output o_data_valid,
        input  i_data_ready,
        output o_data_last,
        output o_frame_last
    );

    modport slave (
        input  o_m0_rd_addr,
        input  o_m0_rd_en,
        output i_m0_rd_data,
        input  o_data,
        input  o_data_valid,
        output i_data_ready,
        input  o_data_last,
        input  o_frame_last
    );
endinterface

// File: rtl/cp_s1_stride_ram_reader.sv
// Multi-chirp strided RAM reader with credit-controlled skid FIFO.
// Issues wrap-around strided reads over a fixed-latency RAM, repeats the sweep
// per chirp with an optional idle gap, and streams the returned words out with
// last/frame_last tags under valid/ready backpressure.
// Optional macro CP_S1_RD_STATS_EN adds o_stall_cnt (saturating stall counter).
module cp_s1_stride_ram_reader #(
    parameter int unsigned DELAY_DATA_ARRIVE = 2,
    parameter int unsigned READ_RAM_WIDTH    = 128,
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned RAM_DEPTH         = 1024,
    parameter int unsigned CNT_WIDTH         = 16,
    parameter int unsigned FIFO_DEPTH        = 8
) (
    input  logic                  clk_200m,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_init_addr,
    input  logic [ADDR_WIDTH-1:0] i_add_addr,
    input  logic [CNT_WIDTH-1:0]  i_data_num,
    input  logic [CNT_WIDTH-1:0]  i_chirp_num,
    input  logic [CNT_WIDTH-1:0]  i_interval,
    output logic                  o_busy,
    output logic                  o_done,
`ifdef CP_S1_RD_STATS_EN
    output logic [31:0]           o_stall_cnt,
`endif
    cp_s1_stride_ram_reader_if.master bus
);

    localparam int unsigned D     = DELAY_DATA_ARRIVE;
    localparam int unsigned OCC_W = $clog2(2 * FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SUM_W = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A      = ADDR_WIDTH'(RAM_DEPTH);
    localparam logic [SUM_W-1:0]      DEPTH_S      = SUM_W'(RAM_DEPTH);
    localparam logic [OCC_W-1:0]      FIFO_DEPTH_O = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_LAST     = PTR_W'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [READ_RAM_WIDTH-1:0] data;
        logic                      last;
        logic                      frame_last;
    } word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cfg_init_q;
    logic [ADDR_WIDTH-1:0] cfg_stride_q;
    logic [CNT_WIDTH-1:0]  cfg_data_num_q;
    logic [CNT_WIDTH-1:0]  cfg_chirp_num_q;
    logic [CNT_WIDTH-1:0]  cfg_interval_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  word_cnt_q;
    logic [CNT_WIDTH-1:0]  chirp_cnt_q;
    logic [CNT_WIDTH-1:0]  gap_cnt_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  iss_last_q;
    logic                  iss_flast_q;
    logic                  busy_q;
    logic                  done_q;

    logic [D-1:0]          pipe_en_q;
    logic [D-1:0]          pipe_last_q;
    logic [D-1:0]          pipe_flast_q;

    word_t                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      mem_cnt_q;
    word_t                 out_q;
    logic                  out_valid_q;

    logic [OCC_W-1:0]      inflight_c;
    logic [OCC_W-1:0]      fifo_total_c;
    logic                  issue_c;
    logic                  pop_c;
    logic                  out_free_c;
    logic                  wr_c;
    word_t                 wr_word_c;
    logic                  mem_push_c;
    logic                  mem_pop_c;
    logic                  drain_done_c;
    logic                  word_last_c;
    logic                  chirp_last_c;
    logic [SUM_W-1:0]      sum_c;
    logic [ADDR_WIDTH-1:0] next_addr_c;
    logic [ADDR_WIDTH-1:0] init_mod_c;

    // Outstanding reads: the one on the RAM port plus those in the latency pipe.
    always_comb begin
        inflight_c = OCC_W'(rd_en_q);
        for (int i = 0; i < int'(D); i++) begin
            inflight_c = inflight_c + OCC_W'(pipe_en_q[i]);
        end
    end

    // Credit check, handshake and FIFO steering decisions.
    always_comb begin
        fifo_total_c = mem_cnt_q + OCC_W'(out_valid_q);
        issue_c      = (state_q == S_RUN) && ((fifo_total_c + inflight_c) < FIFO_DEPTH_O);
        pop_c        = out_valid_q && bus.i_data_ready;
        out_free_c   = !out_valid_q || pop_c;
        wr_c         = pipe_en_q[D-1];
        wr_word_c    = '{data: bus.i_m0_rd_data, last: pipe_last_q[D-1], frame_last: pipe_flast_q[D-1]};
        mem_pop_c    = out_free_c && (mem_cnt_q != '0);
        mem_push_c   = wr_c && !(out_free_c && (mem_cnt_q == '0));
        drain_done_c = (inflight_c == '0) &&
                       ((fifo_total_c == '0) || ((fifo_total_c == OCC_W'(1)) && pop_c));
    end

    // Address stepping with single-subtract wrap, and chirp position flags.
    always_comb begin
        sum_c        = {1'b0, addr_q} + {1'b0, cfg_stride_q};
        next_addr_c  = (sum_c >= DEPTH_S) ? ADDR_WIDTH'(sum_c - DEPTH_S) : ADDR_WIDTH'(sum_c);
        init_mod_c   = i_init_addr % DEPTH_A;
        word_last_c  = (word_cnt_q == (cfg_data_num_q - CNT_WIDTH'(1)));
        chirp_last_c = (chirp_cnt_q == (cfg_chirp_num_q - CNT_WIDTH'(1)));
    end

    // Control FSM with registered RAM-port and status outputs.
    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cfg_init_q      <= '0;
            cfg_stride_q    <= '0;
            cfg_data_num_q  <= '0;
            cfg_chirp_num_q <= '0;
            cfg_interval_q  <= '0;
            addr_q          <= '0;
            word_cnt_q      <= '0;
            chirp_cnt_q     <= '0;
            gap_cnt_q       <= '0;
            rd_en_q         <= 1'b0;
            rd_addr_q       <= '0;
            iss_last_q      <= 1'b0;
            iss_flast_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            rd_en_q <= issue_c;
            done_q  <= 1'b0;
            if (issue_c) begin
                rd_addr_q   <= addr_q;
                iss_last_q  <= word_last_c;
                iss_flast_q <= word_last_c && chirp_last_c;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        cfg_init_q      <= init_mod_c;
                        cfg_stride_q    <= i_add_addr;
                        cfg_data_num_q  <= i_data_num;
                        cfg_chirp_num_q <= (i_chirp_num == '0) ? CNT_WIDTH'(1) : i_chirp_num;
                        cfg_interval_q  <= i_interval;
                        addr_q          <= init_mod_c;
                        word_cnt_q      <= '0;
                        chirp_cnt_q     <= '0;
                        if (i_data_num == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue_c) begin
                        if (word_last_c) begin
                            word_cnt_q <= '0;
                            addr_q     <= cfg_init_q;
                            if (chirp_last_c) begin
                                state_q <= S_DRAIN;
                            end else begin
                                chirp_cnt_q <= chirp_cnt_q + CNT_WIDTH'(1);
                                if (cfg_interval_q != '0) begin
                                    state_q   <= S_GAP;
                                    gap_cnt_q <= cfg_interval_q;
                                end
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
                            addr_q     <= next_addr_c;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == CNT_WIDTH'(1)) begin
                        state_q <= S_RUN;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - CNT_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_done_c) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM latency pipe: enable and issue-time tags travel with each read.
    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            pipe_en_q    <= '0;
            pipe_last_q  <= '0;
            pipe_flast_q <= '0;
        end else begin
            pipe_en_q    <= D'({pipe_en_q, rd_en_q});
            pipe_last_q  <= D'({pipe_last_q, iss_last_q});
            pipe_flast_q <= D'({pipe_flast_q, iss_flast_q});
        end
    end

    // Skid FIFO storage (payload only, no reset needed).
    always_ff @(posedge clk_200m) begin
        if (mem_push_c) begin
            mem[wr_ptr_q] <= wr_word_c;
        end
    end

    // Skid FIFO pointers/count and registered output stage with bypass when empty.
    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (mem_push_c) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (mem_pop_c) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({mem_push_c, mem_pop_c})
                2'b10:   mem_cnt_q <= mem_cnt_q + OCC_W'(1);
                2'b01:   mem_cnt_q <= mem_cnt_q - OCC_W'(1);
                default: mem_cnt_q <= mem_cnt_q;
            endcase
            if (out_free_c) begin
                if (mem_pop_c) begin
                    out_q       <= mem[rd_ptr_q];
                    out_valid_q <= 1'b1;
                end else if (wr_c) begin
                    out_q       <= wr_word_c;
                    out_valid_q <= 1'b1;
                end else begin
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef CP_S1_RD_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where a word waits on downstream ready.
    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_IDLE) && i_start) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !bus.i_data_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

    assign bus.o_m0_rd_addr = rd_addr_q;
    assign bus.o_m0_rd_en   = rd_en_q;
    assign bus.o_data       = out_q.data;
    assign bus.o_data_valid = out_valid_q;
    assign bus.o_data_last  = out_q.last;
    assign bus.o_frame_last = out_q.frame_last;
    assign o_busy           = busy_q;
    assign o_done           = done_q;

endmodule

// File: tb/tb_cp_s1_stride_ram_reader.sv
// Bench for cp_s1_stride_ram_reader: 2-cycle RAM model, arithmetic reference
// of the read sequence, randomized configs and ready patterns.
`timescale 1ns/1ps
module tb_cp_s1_stride_ram_reader;

    localparam int unsigned D     = 2;
    localparam int unsigned W     = 128;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned CW    = 16;
    localparam int unsigned FD    = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic         f;
    } ew_t;

    logic          clk_200m = 1'b0;
    logic          rst_n    = 1'b0;
    logic          i_start  = 1'b0;
    logic [AW-1:0] i_init_addr = '0;
    logic [AW-1:0] i_add_addr  = '0;
    logic [CW-1:0] i_data_num  = '0;
    logic [CW-1:0] i_chirp_num = '0;
    logic [CW-1:0] i_interval  = '0;
    logic          o_busy;
    logic          o_done;
`ifdef CP_S1_RD_STATS_EN
    logic [31:0]   o_stall_cnt;
`endif

    cp_s1_stride_ram_reader_if #(.ADDR_WIDTH(AW), .READ_RAM_WIDTH(W)) bus ();

    cp_s1_stride_ram_reader #(
        .DELAY_DATA_ARRIVE(D), .READ_RAM_WIDTH(W), .ADDR_WIDTH(AW),
        .RAM_DEPTH(DEPTH), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
    ) dut (
        .clk_200m    (clk_200m),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_init_addr (i_init_addr),
        .i_add_addr  (i_add_addr),
        .i_data_num  (i_data_num),
        .i_chirp_num (i_chirp_num),
        .i_interval  (i_interval),
        .o_busy      (o_busy),
        .o_done      (o_done),
`ifdef CP_S1_RD_STATS_EN
        .o_stall_cnt (o_stall_cnt),
`endif
        .bus         (bus)
    );

    always #5 clk_200m = ~clk_200m;

    // RAM with 2-cycle read latency
    logic [W-1:0] ram [DEPTH];
    logic [W-1:0] ram_p1;
    always @(posedge clk_200m) begin
        ram_p1           <= ram[bus.o_m0_rd_addr[9:0]];
        bus.i_m0_rd_data <= ram_p1;
    end

    int cyc = 0;
    always @(posedge clk_200m) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    ew_t           exp_word[$];
    int unsigned   exp_addr[$];
    int            rd_cycles[$];
    int unsigned   seen_addr[$];
    int            done_cycles[$];
    int            issued = 0;
    int            xfers  = 0;
    int            stalls = 0;
    bit            mon_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [W-1:0]  prev_data;
    logic          prev_l, prev_f;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        exp_word.delete(); exp_addr.delete(); rd_cycles.delete();
        seen_addr.delete(); done_cycles.delete();
        issued = 0; xfers = 0; stalls = 0; prev_stall = 1'b0;
    endtask

    // Reference: address i of every chirp is (init mod DEPTH + i*stride) mod DEPTH.
    task automatic build_model(input logic [AW-1:0] init, input logic [AW-1:0] stride,
                               input int n, input int ch);
        int unsigned base, a;
        int nc;
        ew_t e;
        nc   = (ch == 0) ? 1 : ch;
        base = init % DEPTH;
        for (int c = 0; c < nc; c++) begin
            for (int i = 0; i < n; i++) begin
                a = (base + int'(i) * stride) % DEPTH;
                exp_addr.push_back(a);
                e.d = ram[a];
                e.l = (i == n - 1);
                e.f = (i == n - 1) && (c == nc - 1);
                exp_word.push_back(e);
            end
        end
    endtask

    // Monitor: address order, credit bound, stall stability, output words, tags.
    always @(negedge clk_200m) begin
        if (rst_n && mon_en) begin
            if (bus.o_m0_rd_en) begin
                if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
                else chk("rd_addr", bus.o_m0_rd_addr, exp_addr.pop_front());
                rd_cycles.push_back(cyc);
                seen_addr.push_back(bus.o_m0_rd_addr);
                issued++;
            end
            chk("credit_bound", ((issued - xfers) <= int'(FD)), 1);
            if (prev_stall) begin
                chk("hold_valid", bus.o_data_valid, 1);
                chk("hold_data", bus.o_data, prev_data);
                chk("hold_tags", {bus.o_data_last, bus.o_frame_last}, {prev_l, prev_f});
            end
            if (!bus.o_data_valid)
                chk("tags_idle", {bus.o_data_last, bus.o_frame_last}, 0);
            if (bus.o_data_valid && bus.i_data_ready) begin
                if (exp_word.size() == 0) chk("out_extra", 1, 0);
                else begin
                    ew_t e;
                    e = exp_word.pop_front();
                    chk("out_data", bus.o_data, e.d);
                    chk("out_tags", {bus.o_data_last, bus.o_frame_last}, {e.l, e.f});
                end
                xfers++;
            end
            if (bus.o_data_valid && !bus.i_data_ready) stalls++;
            prev_stall = bus.o_data_valid && !bus.i_data_ready;
            prev_data  = bus.o_data;
            prev_l     = bus.o_data_last;
            prev_f     = bus.o_frame_last;
            if (o_done) done_cycles.push_back(cyc);
        end
    end

    task automatic start_frame(input logic [AW-1:0] init, input logic [AW-1:0] stride,
                               input int n, input int ch, input int iv);
        clear_sb();
        build_model(init, stride, n, ch);
        @(posedge clk_200m); #1;
        i_init_addr = init; i_add_addr = stride;
        i_data_num = CW'(n); i_chirp_num = CW'(ch); i_interval = CW'(iv);
        i_start = 1'b1;
        @(posedge clk_200m); #1;
        i_start = 1'b0;
        // later config changes must be ignored
        i_init_addr = $urandom; i_add_addr = $urandom;
        i_data_num = CW'($urandom); i_chirp_num = CW'($urandom); i_interval = CW'($urandom);
        if (n != 0) chk("busy_after_start", o_busy, 1);
    endtask

    // mode 0: ready=1; 1: 30% duty; 2: 30% duty plus 20-cycle hold-low.
    task automatic wait_done(input int budget, input int mode);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk_200m); #1;
            if (o_done) found = 1'b1;
            else if (mode == 0) bus.i_data_ready = 1'b1;
            else if (mode == 2 && i >= 40 && i < 60) bus.i_data_ready = 1'b0;
            else bus.i_data_ready = ($urandom_range(0, 99) < 30);
        end
        if (!found) chk("done_timeout", 0, 1);
        bus.i_data_ready = 1'b1;
        @(posedge clk_200m); #1;
        @(posedge clk_200m); #1;
        chk("done_single_pulse", done_cycles.size(), 1);
        chk("done_low_after", o_done, 0);
        chk("busy_low_after", o_busy, 0);
        chk("words_left", exp_word.size(), 0);
        chk("addr_left", exp_addr.size(), 0);
    endtask

    logic [AW-1:0] wrap_exp [4];

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        bus.i_data_ready = 1'b1;
        wrap_exp = '{32'd1000, 32'd1016, 32'd8, 32'd24};

        // reset state
        repeat (3) @(posedge clk_200m);
        #1;
        chk("rst_rd_en", bus.o_m0_rd_en, 0);
        chk("rst_valid", bus.o_data_valid, 0);
        chk("rst_busy_done", {o_busy, o_done}, 0);
        rst_n = 1'b1;
        @(posedge clk_200m); #1;
        chk("idle_outputs", {bus.o_m0_rd_en, bus.o_data_valid, bus.o_data_last,
                             bus.o_frame_last, o_busy, o_done}, 0);
        chk("idle_addr", bus.o_m0_rd_addr, 0);
        mon_en = 1'b1;

        // basic full sweep
        start_frame(32'd0, 32'd1, 1024, 1, 0);
        wait_done(5000, 0);
        chk("sweep_reads", rd_cycles.size(), 1024);
        chk("sweep_words", xfers, 1024);
        if (rd_cycles.size() == 1024) begin
            chk("sweep_no_bubble", rd_cycles[1023] - rd_cycles[0], 1023);
            chk("sweep_last_addr", seen_addr[1023], 1023);
            if (done_cycles.size() == 1)
                chk("done_latency", done_cycles[0] - rd_cycles[1023], D + 2);
        end

        // stride wrap
        start_frame(32'd1000, 32'd16, 4, 1, 0);
        wait_done(500, 0);
        chk("wrap_reads", seen_addr.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) chk("wrap_addr", seen_addr[i], wrap_exp[i]);

        // multi-chirp with gap
        start_frame(32'd37, 32'd3, 8, 3, 50);
        wait_done(1000, 0);
        chk("mc_reads", rd_cycles.size(), 24);
        if (rd_cycles.size() == 24) begin
            chk("mc_gap1", rd_cycles[8] - rd_cycles[7], 51);
            chk("mc_gap2", rd_cycles[16] - rd_cycles[15], 51);
            chk("mc_chirp_b2b", rd_cycles[7] - rd_cycles[0], 7);
        end

        // multi-chirp without gap
        start_frame(32'd900, 32'd200, 8, 3, 0);
        wait_done(1000, 0);
        chk("nogap_reads", rd_cycles.size(), 24);
        if (rd_cycles.size() == 24) chk("nogap_b2b", rd_cycles[23] - rd_cycles[0], 23);

        // randomized backpressure frames
        for (int k = 0; k < 3; k++) begin
            start_frame($urandom, 32'($urandom_range(0, DEPTH - 1)), $urandom_range(20, 60),
                        $urandom_range(0, 3), $urandom_range(0, 5));
            wait_done(6000, (k == 0) ? 2 : 1);
`ifdef CP_S1_RD_STATS_EN
            chk("stall_cnt", o_stall_cnt, stalls);
`endif
        end

        // data_num = 0
        start_frame(32'd5, 32'd1, 0, 2, 3);
        chk("zero_done", o_done, 1);
        chk("zero_busy", o_busy, 0);
        @(posedge clk_200m); #1;
        chk("zero_done_pulse", o_done, 0);
        repeat (4) @(posedge clk_200m);
        #1;
        chk("zero_no_reads", rd_cycles.size(), 0);

        // reset mid-run, then clean restart
        start_frame(32'd300, 32'd7, 200, 1, 0);
        repeat (20) @(posedge clk_200m);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", {bus.o_m0_rd_en, bus.o_data_valid, bus.o_data_last, bus.o_frame_last}, 0);
        chk("mid_rst_addr", bus.o_m0_rd_addr, 0);
        chk("mid_rst_data", bus.o_data, 0);
        chk("mid_rst_status", {o_busy, o_done}, 0);
`ifdef CP_S1_RD_STATS_EN
        chk("mid_rst_stall", o_stall_cnt, 0);
`endif
        repeat (3) @(posedge clk_200m);
        #1;
        clear_sb();
        rst_n = 1'b1;
        start_frame(32'd300, 32'd7, 200, 1, 0);
        wait_done(2000, 1);
        if (seen_addr.size() > 0) chk("restart_first_addr", seen_addr[0], 300);
        else chk("restart_reads", 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
